id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage directly upstream of the ALU.
- Captures decoded operands and control from ID each cycle, and resolves EX/MEM and MEM/WB forwarding. Drives src_A, src_B and alu_control straight into the ALU.
- Detects load-use hazards: requests an ID/IF stall and inserts a bubble into EX.

Parameters:
XLEN, 32, datapath width
REGW, 5, register index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
stall  in  1  external hold (memory busy); EX register keeps its contents
flush  in  1  squash EX (branch/jump taken); next EX is a bubble
id_valid  in  1  ID holds a real instruction
id_rd1, id_rd2  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_pc  in  XLEN  PC of ID instruction
id_rs1, id_rs2, id_rd  in  REGW  register indices
id_alu_control  in  3  ALU op (000 add, 001 sub, 010 and, 011 or, 100 slt)
id_alu_src  in  1  0: src_B = rs2 value, 1: src_B = imm
id_reg_write, id_mem_write  in  1  write enables
id_result_src  in  2  00 ALU, 01 load, 10 PC+4
mem_rd  in  REGW  destination index in MEM
mem_reg_write  in  1  MEM writes a register
mem_fwd_data  in  XLEN  MEM result available for forwarding
wb_rd  in  REGW  destination index in WB
wb_reg_write  in  1  WB writes a register
wb_result  in  XLEN  WB write-back data
load_use_stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
src_A, src_B  out  XLEN  ALU operands
alu_control  out  3  ALU op
ex_write_data  out  XLEN  forwarded rs2 value for stores
ex_pc  out  XLEN  PC of EX instruction
ex_rd  out  REGW  destination index
ex_reg_write, ex_mem_write  out  1  gated by ex_valid
ex_result_src  out  2  result select

Behaviour:
- EX register update priority, evaluated on each clk rising edge:
  1. reset (asynchronous): all EX fields are zero, including ex_valid=0, enables=0, alu_control=000, ex_result_src=00. All data outputs are therefore 0 and load_use_stall=0.
  2. flush: bubble (ex_valid=0, reg_write=0, mem_write=0, ex_rd=0). Other fields don't-care but must be zeroed.
  3. stall: hold all fields.
  4. load_use_stall: bubble.
  5. otherwise: load all id_* fields; ex_valid=id_valid.
- flush and stall together: flush wins.
- load_use_stall is combinational: ex_valid & ex_result_src==01 & ex_rd!=0 & (ex_rd==id_rs1 | (ex_rd==id_rs2 & id_rs2 used)).
  - Treat rs2 as used when id_alu_src==0 or id_mem_write==1.
  - Asserted only when id_valid=1. Forced to 0 while flush=1.
- Forwarding, combinational from the registered fields, per operand (rs1 and rs2 alike):
  - Priority 1: mem_reg_write & mem_rd!=0 & mem_rd==ex_rsN -> mem_fwd_data.
  - Priority 2: wb_reg_write & wb_rd!=0 & wb_rd==ex_rsN -> wb_result.
  - Else the registered id_rdN.
  - x0 is never forwarded; its value is always the registered value (0 from the register file).
- src_A = fwdA. src_B = ex_alu_src ? ex_imm : fwdB. ex_write_data = fwdB regardless of alu_src.
- Latency: one cycle from ID capture to the EX outputs. Forwarding adds no cycle.
- The register file is write-first, so the same-cycle WB-to-ID case is covered there, not here.
- Bubbles present alu_control=000 and operands per the zeroed fields. Downstream must qualify with ex_valid.
- Reset mid-operation discards the EX contents immediately, with no wait for a clock edge.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU op constants ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_SLT=100.
  - Result-source constants RES_ALU=00, RES_LOAD=01, RES_PC4=10.
  - XLEN and REGW.
- One sub-module: fwd_unit. Purely combinational; takes ex_rs1/ex_rs2 plus the MEM/WB indices and enables, and returns the two 2-bit select values. Instantiate it once, with the operand muxes in id_ex_stage.

Test Plan:
- Reset: assert reset mid-cycle with ex_valid=1 -> within the same cycle ex_valid=0, src_A=0, ex_reg_write=0, load_use_stall=0.
- Basic pass-through: id_rd1=5, id_imm=7, alu_src=1, alu_control=000, valid, no hazards -> next cycle src_A=5, src_B=7, alu_control=000, ex_valid=1.
- MEM-over-WB priority: ex_rs1=3, mem_rd=3, mem_fwd_data=0xAA, wb_rd=3, wb_result=0xBB, both reg_write -> src_A=0xAA. Drop mem_reg_write -> src_A=0xBB. Set mem_rd=wb_rd=0 -> src_A stays at the registered value.
- Load-use: EX holds a load with rd=4; ID has rs1=4 -> load_use_stall=1 and next EX is a bubble. Repeat with rd=0 -> no stall.
- Store forwarding: ex_rs2=6, alu_src=1, mem_write=1, wb_rd=6, wb_result=0x1234 -> ex_write_data=0x1234 and src_B=imm.
- Stall/flush: stall=1 for 3 cycles -> EX outputs unchanged. Then stall=1 & flush=1 -> bubble. Then flush with load_use_stall condition present -> load_use_stall=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 datapath widths, ALU/result-select encodings and the EX pipeline record.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // Operand source selects produced by the forwarding unit.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
  } ex_reg_t;

  // MEM is the younger producer, so it beats WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [REGW-1:0] rs,
                                         input logic [REGW-1:0] mem_rd,
                                         input logic            mem_we,
                                         input logic [REGW-1:0] wb_rd,
                                         input logic            wb_we);
    if (mem_we && (mem_rd != '0) && (mem_rd == rs)) return FWD_MEM;
    if (wb_we && (wb_rd != '0) && (wb_rd == rs))    return FWD_WB;
    return FWD_REG;
  endfunction
endpackage

// File: rtl/fwd_unit.sv
// Combinational EX operand forwarding selects for rs1 and rs2.
module fwd_unit
  import riscv_pkg::*;
(
  input  logic [REGW-1:0] ex_rs1,
  input  logic [REGW-1:0] ex_rs2,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_write,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b
);
  assign fwd_a = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
  assign fwd_b = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use hazard detection.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [2:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_write,
  input  logic [1:0]      id_result_src,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] src_A,
  output logic [XLEN-1:0] src_B,
  output logic [2:0]      alu_control,
  output logic [XLEN-1:0] ex_write_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_write,
  output logic [1:0]      ex_result_src
);
  ex_reg_t         ex_q, ex_d;
  logic            rs2_used;
  logic [1:0]      fwd_a, fwd_b;
  logic [XLEN-1:0] fwd_a_val, fwd_b_val;

  // rs2 only matters when it feeds the ALU or supplies store data.
  assign rs2_used = !id_alu_src || id_mem_write;

  assign load_use_stall = id_valid && !flush && ex_q.valid &&
                          (ex_q.result_src == RES_LOAD) && (ex_q.rd != '0) &&
                          ((ex_q.rd == id_rs1) || ((ex_q.rd == id_rs2) && rs2_used));

  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (load_use_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid       = id_valid;
      ex_d.pc          = id_pc;
      ex_d.rd1         = id_rd1;
      ex_d.rd2         = id_rd2;
      ex_d.imm         = id_imm;
      ex_d.rs1         = id_rs1;
      ex_d.rs2         = id_rs2;
      ex_d.rd          = id_rd;
      ex_d.alu_control = id_alu_control;
      ex_d.alu_src     = id_alu_src;
      ex_d.reg_write   = id_reg_write;
      ex_d.mem_write   = id_mem_write;
      ex_d.result_src  = id_result_src;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  fwd_unit u_fwd (
    .ex_rs1        (ex_q.rs1),
    .ex_rs2        (ex_q.rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  always_comb begin
    unique case (fwd_a)
      FWD_MEM: fwd_a_val = mem_fwd_data;
      FWD_WB:  fwd_a_val = wb_result;
      default: fwd_a_val = ex_q.rd1;
    endcase
    unique case (fwd_b)
      FWD_MEM: fwd_b_val = mem_fwd_data;
      FWD_WB:  fwd_b_val = wb_result;
      default: fwd_b_val = ex_q.rd2;
    endcase
  end

  assign src_A         = fwd_a_val;
  assign src_B         = ex_q.alu_src ? ex_q.imm : fwd_b_val;
  assign ex_write_data = fwd_b_val;
  assign alu_control   = ex_q.alu_control;
  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.valid && ex_q.reg_write;
  assign ex_mem_write  = ex_q.valid && ex_q.mem_write;
  assign ex_result_src = ex_q.result_src;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expected values.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_alu_control;
  logic        id_alu_src, id_reg_write, id_mem_write;
  logic [1:0]  id_result_src;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_fwd_data, wb_result;
  logic        load_use_stall, ex_valid;
  logic [31:0] src_A, src_B, ex_write_data, ex_pc;
  logic [2:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_write;
  logic [1:0]  ex_result_src;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_control(id_alu_control), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_mem_write(id_mem_write),
    .id_result_src(id_result_src),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_fwd_data(mem_fwd_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid),
    .src_A(src_A), .src_B(src_B), .alu_control(alu_control),
    .ex_write_data(ex_write_data), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_result_src(ex_result_src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rd1 = 0; id_rd2 = 0; id_imm = 0; id_pc = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_control = 3'b000;
    id_alu_src = 0; id_reg_write = 0; id_mem_write = 0; id_result_src = 2'b00;
  endtask

  task automatic clear_fwd();
    mem_rd = 0; mem_reg_write = 0; mem_fwd_data = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    clear_id();
    clear_fwd();
    tick();
    tick();
    reset = 0;
    check("rst_valid", {31'b0, ex_valid}, 0);
    check("rst_srcA", src_A, 0);
    check("rst_alu", {29'b0, alu_control}, 0);
    check("rst_lus", {31'b0, load_use_stall}, 0);

    // Basic pass-through
    id_valid = 1; id_rd1 = 5; id_imm = 7; id_alu_src = 1; id_alu_control = 3'b000;
    id_rs1 = 1; id_rs2 = 2; id_rd = 3; id_reg_write = 1;
    tick();
    check("pt_srcA", src_A, 5);
    check("pt_srcB", src_B, 7);
    check("pt_alu", {29'b0, alu_control}, 0);
    check("pt_valid", {31'b0, ex_valid}, 1);
    check("pt_rd", {27'b0, ex_rd}, 3);
    check("pt_rw", {31'b0, ex_reg_write}, 1);

    // Asynchronous reset mid-cycle
    #2 reset = 1;
    #1;
    check("arst_valid", {31'b0, ex_valid}, 0);
    check("arst_srcA", src_A, 0);
    check("arst_rw", {31'b0, ex_reg_write}, 0);
    check("arst_lus", {31'b0, load_use_stall}, 0);
    reset = 0;

    // MEM-over-WB priority on rs1
    clear_id();
    id_valid = 1; id_rs1 = 3; id_rd1 = 32'h11; id_rs2 = 0; id_rd2 = 32'h22;
    id_rd = 5; id_reg_write = 1; id_alu_control = 3'b001;
    tick();
    mem_rd = 3; mem_reg_write = 1; mem_fwd_data = 32'hAA;
    wb_rd = 3; wb_reg_write = 1; wb_result = 32'hBB;
    #1 check("fwd_mem", src_A, 32'hAA);
    check("fwd_alu_sub", {29'b0, alu_control}, 3'b001);
    mem_reg_write = 0;
    #1 check("fwd_wb", src_A, 32'hBB);
    mem_reg_write = 1; mem_rd = 0; wb_rd = 0;
    #1 check("fwd_x0_A", src_A, 32'h11);
    check("fwd_x0_B", src_B, 32'h22);
    check("fwd_x0_wd", ex_write_data, 32'h22);

    // Store data forwarding via WB
    clear_id();
    clear_fwd();
    id_valid = 1; id_rs1 = 0; id_rd1 = 32'h100; id_rs2 = 6; id_rd2 = 32'h99;
    id_imm = 32'h40; id_alu_src = 1; id_mem_write = 1; id_pc = 32'h1000;
    tick();
    wb_rd = 6; wb_reg_write = 1; wb_result = 32'h1234;
    #1 check("st_wdata", ex_write_data, 32'h1234);
    check("st_srcB", src_B, 32'h40);
    check("st_mw", {31'b0, ex_mem_write}, 1);
    check("st_rw", {31'b0, ex_reg_write}, 0);
    clear_fwd();

    // Stall holds EX while ID changes
    stall = 1;
    id_rd1 = 32'hDEAD; id_pc = 32'h2000; id_mem_write = 0; id_rd = 8; id_reg_write = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_srcA", src_A, 32'h100);
      check("stall_pc", ex_pc, 32'h1000);
      check("stall_mw", {31'b0, ex_mem_write}, 1);
    end
    flush = 1;
    tick();
    check("sf_valid", {31'b0, ex_valid}, 0);
    check("sf_mw", {31'b0, ex_mem_write}, 0);
    check("sf_rd", {27'b0, ex_rd}, 0);
    check("sf_srcA", src_A, 0);
    flush = 0; stall = 0;

    // Load-use on rs1
    clear_id();
    id_valid = 1; id_rs1 = 2; id_rd1 = 32'h200; id_imm = 8; id_alu_src = 1;
    id_rd = 4; id_reg_write = 1; id_result_src = 2'b01;
    tick();
    clear_id();
    id_valid = 1; id_rs1 = 4; id_rd1 = 32'h55; id_alu_src = 1; id_rd = 7; id_reg_write = 1;
    #1 check("lu_stall", {31'b0, load_use_stall}, 1);
    tick();
    check("lu_bub_valid", {31'b0, ex_valid}, 0);
    check("lu_bub_rd", {27'b0, ex_rd}, 0);
    check("lu_bub_rw", {31'b0, ex_reg_write}, 0);
    check("lu_bub_lus", {31'b0, load_use_stall}, 0);
    tick();
    check("lu_after_valid", {31'b0, ex_valid}, 1);
    check("lu_after_rd", {27'b0, ex_rd}, 7);
    check("lu_after_srcA", src_A, 32'h55);

    // Load to x0 never stalls
    clear_id();
    id_valid = 1; id_rs1 = 2; id_alu_src = 1; id_rd = 0; id_result_src = 2'b01;
    tick();
    clear_id();
    id_valid = 1; id_rs1 = 0; id_rs2 = 0;
    #1 check("lu_x0", {31'b0, load_use_stall}, 0);

    // rs2 usage qualification
    clear_id();
    id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_alu_src = 1; id_rd = 9;
    id_reg_write = 1; id_result_src = 2'b01;
    tick();
    clear_id();
    id_valid = 1; id_rs1 = 1; id_rs2 = 9; id_alu_src = 1; id_mem_write = 0;
    #1 check("lu_rs2_unused", {31'b0, load_use_stall}, 0);
    id_alu_src = 0;
    #1 check("lu_rs2_alu", {31'b0, load_use_stall}, 1);
    id_alu_src = 1; id_mem_write = 1;
    #1 check("lu_rs2_store", {31'b0, load_use_stall}, 1);
    id_valid = 0;
    #1 check("lu_id_invalid", {31'b0, load_use_stall}, 0);
    id_valid = 1; id_mem_write = 0; id_alu_src = 0; flush = 1;
    #1 check("lu_flush_mask", {31'b0, load_use_stall}, 0);
    tick();
    check("flush_valid", {31'b0, ex_valid}, 0);
    check("flush_rs", {30'b0, ex_result_src}, 0);
    flush = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
